sub16bit_seq: RTL and testbench
===============================

Name: sub16bit_seq

Overview:
- Multi-cycle 16-bit subtractor, the inverse operation to the team's 16-bit ripple adder.
- Computes Y = A - B - Bin one 4-bit slice per clock, using a single slice datapath. This trades latency for area.
- Uses a valid/ready handshake on input and output.
- Sits beside the adder in the arithmetic unit wherever a registered, back-pressurable difference is needed.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of SLICE.
- SLICE, 4, bits processed per clock cycle; the number of compute cycles is N = WIDTH/SLICE.

Ports:
- clk  input  1  system clock, all state changes on the rising edge
- rst_n  input  1  asynchronous reset, active low
- in_valid  input  1  A/B/Bin are presented
- in_ready  output  1  block can accept an operand pair
- A  input  WIDTH  minuend
- B  input  WIDTH  subtrahend
- Bin  input  1  borrow in
- out_valid  output  1  Y/Bout hold a completed result
- out_ready  input  1  consumer takes the result
- Y  output  WIDTH  difference A - B - Bin, modulo 2^WIDTH
- Bout  output  1  borrow out; 1 when A < B + Bin, unsigned

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n is asynchronous and active-low: while it is low, all state clears immediately, independent of clk.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - Y = 0, Bout = 0, all internal operand, carry and slice-counter registers = 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On a clock edge with in_valid = 1: latch A, B, and carry = ~Bin; set the slice index k = 0; go to CALC.
  - in_ready drops to 0 in the cycle after acceptance.
- CALC:
  - in_ready = 0. Each cycle processes slice k, bits [k*SLICE + SLICE-1 : k*SLICE].
  - Per slice: {c, d} = A_k + ~B_k + carry, computed at SLICE+1 bits. Store d into result bits k; carry <= c; k <= k + 1.
  - After the slice with k = N-1: Y <= assembled result, Bout <= ~c, go to DONE.
  - Takes exactly N cycles (4 at defaults).
- DONE:
  - out_valid = 1; Y and Bout stay stable.
  - On an edge with out_ready = 1: out_valid <= 0, go to IDLE.
- Latency and throughput:
  - out_valid rises N clock edges after the accepting edge.
  - One operation per N+2 cycles.
  - No new acceptance occurs in the DONE cycle, even if in_valid and out_ready are both high.
- Output stability:
  - Y and Bout change only on entry to DONE or on reset.
  - Between operations they keep the last result, so out_valid = 0 does not clear them.
- Input sampling:
  - A, B, Bin are sampled only on the accepting edge.
  - Input changes during CALC or DONE are ignored.
- Back-pressure:
  - out_ready may stay low indefinitely; the block holds in DONE with its outputs unchanged.
  - in_valid is ignored while in_ready = 0.
- Reset mid-operation:
  - The operation is abandoned and out_valid is never asserted for it.
  - After rst_n rises, the block is in IDLE with in_ready = 1.
- Arithmetic:
  - All arithmetic is unsigned and modulo 2^WIDTH.
  - Bin = 1 with A = B gives Y = all ones and Bout = 1.

Optional Feature:
- Macro: SUB16BIT_SEQ_OVF_EN.
- When defined:
  - Adds output port V (output, 1 bit): signed two's-complement overflow of A - B - Bin.
  - V = carry into the MSB XOR carry out of the MSB, captured from the final slice.
  - V updates together with Y on entry to DONE; reset value 0.
- When undefined: port V does not exist and there is no extra logic.

Test Plan:
- After reset, check in_ready = 1, out_valid = 0, Y = 0x0000, Bout = 0. Then present A = 0x1234, B = 0x0234, Bin = 0 → out_valid exactly 4 edges after acceptance, Y = 0x1000, Bout = 0.
- A = 0x0000, B = 0x0001, Bin = 0 → Y = 0xFFFF, Bout = 1. This exercises borrow ripple through all slices.
- A = 0x0010, B = 0x000F, Bin = 1 → Y = 0x0000, Bout = 0. Also A = 0x5555, B = 0x5555, Bin = 1 → Y = 0xFFFF, Bout = 1.
- Back-pressure: A = 0xABCD, B = 0x0001, Bin = 0 → Y = 0xABCC. Hold out_ready = 0 for 10 cycles while changing A and B and pulsing in_valid → Y stable, in_ready = 0. Then out_ready = 1 for one edge → out_valid = 0, and in_ready = 1 on the next cycle.
- Reset mid-operation: drop rst_n asynchronously during the 2nd CALC cycle → out_valid = 0 and Y = 0 immediately. After release, a new operation 0x0003 - 0x0001 gives Y = 0x0002 with normal latency.
- With SUB16BIT_SEQ_OVF_EN defined:
  - A = 0x8000, B = 0x0001 → Y = 0x7FFF, V = 1.
  - A = 0x7FFF, B = 0xFFFF → Y = 0x8000, V = 1.
  - A = 0x0005, B = 0x0003 → Y = 0x0002, V = 0.

Source files
------------

// File: rtl/sub16bit_seq_if.sv
// Handshake/data bundle for the multi-cycle subtractor.
// Optional signed-overflow flag V is present when SUB16BIT_SEQ_OVF_EN is defined.
interface sub16bit_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Y;
    logic             Bout;
`ifdef SUB16BIT_SEQ_OVF_EN
    logic             V;

    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, Y, Bout, V
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, Y, Bout, V
    );
`else
    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, Y, Bout
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, Y, Bout
    );
`endif
endinterface

// File: rtl/sub16bit_seq.sv
// Multi-cycle subtractor: Y = A - B - Bin, one SLICE-bit slice per clock through a single slice adder.
// Define SUB16BIT_SEQ_OVF_EN to add the signed-overflow output V.
module sub16bit_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    sub16bit_seq_if.slave      bus
);

    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              carry_q, carry_d;
    logic [KW-1:0]     k_q, k_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic              bout_q, bout_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [SLICE-1:0]  a_sl;
    logic [SLICE-1:0]  nb_sl;
    logic [SLICE:0]    slice_sum;
    logic [SLICE-1:0]  d;
    logic              c;

`ifdef SUB16BIT_SEQ_OVF_EN
    logic              v_q, v_d;
    assign bus.V = v_q;
`endif

    // Operands shift right so the active slice always sits in the low bits
    assign a_sl      = a_q[SLICE-1:0];
    assign nb_sl     = ~b_q[SLICE-1:0];
    assign slice_sum = {1'b0, a_sl} + {1'b0, nb_sl} + {{SLICE{1'b0}}, carry_q};
    assign d         = slice_sum[SLICE-1:0];
    assign c         = slice_sum[SLICE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            k_q         <= '0;
            y_q         <= '0;
            bout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SUB16BIT_SEQ_OVF_EN
            v_q         <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            k_q         <= k_d;
            y_q         <= y_d;
            bout_q      <= bout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SUB16BIT_SEQ_OVF_EN
            v_q         <= v_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        k_d     = k_q;
        y_d     = y_q;
        bout_d  = bout_q;
`ifdef SUB16BIT_SEQ_OVF_EN
        v_d     = v_q;
`endif
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    carry_d = ~bus.Bin;
                    k_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Result fills from the top; after N slices slice 0 lands in the low bits
                a_d     = a_q >> SLICE;
                b_d     = b_q >> SLICE;
                res_d   = {d, res_q[WIDTH-1:SLICE]};
                carry_d = c;
                k_d     = k_q + KW'(1);
                if (k_q == KW'(N - 1)) begin
                    y_d     = {d, res_q[WIDTH-1:SLICE]};
                    bout_d  = ~c;
`ifdef SUB16BIT_SEQ_OVF_EN
                    // Carry into MSB recovered from the MSB sum bit
                    v_d     = a_sl[SLICE-1] ^ nb_sl[SLICE-1] ^ d[SLICE-1] ^ c;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Y         = y_q;
    assign bus.Bout      = bout_q;

endmodule

// File: tb/tb_sub16bit_seq.sv
// Scoreboard bench for sub16bit_seq: driver pushes reference results, monitor pops on each output handshake.
module tb_sub16bit_seq;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    bit   rand_ready;

    typedef struct {
        logic [15:0] y;
        logic        bout;
        logic        v;
    } exp_t;

    exp_t exp_q[$];

    sub16bit_seq_if #(.WIDTH(16)) bus ();

    sub16bit_seq #(.WIDTH(16), .SLICE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: plain wide unsigned and signed integer arithmetic
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
        exp_t        e;
        logic [16:0] diff;
        int          sd;
        diff   = {1'b0, a} - {1'b0, b} - {16'd0, bin};
        e.y    = diff[15:0];
        e.bout = diff[16];
        sd     = int'($signed(a)) - int'($signed(b)) - int'(bin);
        e.v    = (sd > 32767) || (sd < -32768);
        return e;
    endfunction

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bin);
        int waited;
        int lat;
        waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            return;
        end
        bus.A        = a;
        bus.B        = b;
        bus.Bin      = bin;
        bus.in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(a, b, bin));
        #1;
        bus.in_valid = 1'b0;
        bus.A        = 16'($urandom);
        bus.B        = 16'($urandom);
        bus.Bin      = 1'($urandom);
        check("in_ready_drop", 32'(bus.in_ready), 32'd0);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        check("latency", 32'(lat), 32'd4);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compare on every accepted output
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("Y", 32'(bus.Y), 32'(e.y));
                    check("Bout", 32'(bus.Bout), 32'(e.bout));
`ifdef SUB16BIT_SEQ_OVF_EN
                    check("V", 32'(bus.V), 32'(e.v));
`endif
                end
            end
        end
    end

    // Random consumer back-pressure
    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        rand_ready    = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Bin       = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_Y", 32'(bus.Y), 32'h0);
        check("rst_Bout", 32'(bus.Bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(16'h1234, 16'h0234, 1'b0);
        do_op(16'h0000, 16'h0001, 1'b0);
        do_op(16'h0010, 16'h000F, 1'b1);
        do_op(16'h5555, 16'h5555, 1'b1);
        do_op(16'h8000, 16'h0001, 1'b0);
        do_op(16'h7FFF, 16'hFFFF, 1'b0);
        do_op(16'h0005, 16'h0003, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 1'b0);
        drain();

        // Back-pressure: result must hold while the consumer stalls
        bus.out_ready = 1'b0;
        do_op(16'hABCD, 16'h0001, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.A        = 16'($urandom);
            bus.B        = 16'($urandom);
            bus.Bin      = 1'($urandom);
            bus.in_valid = ~bus.in_valid;
            #2;
            check("bp_Y", 32'(bus.Y), 32'hABCC);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        drain();

        // Reset during the second CALC cycle abandons the operation
        @(negedge clk);
        bus.A        = 16'hFFFF;
        bus.B        = 16'h0001;
        bus.Bin      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_Y", 32'(bus.Y), 32'h0);
        check("mid_rst_Bout", 32'(bus.Bout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        do_op(16'h0003, 16'h0001, 1'b0);
        drain();

        // Random operands with random consumer stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
            do_op(ra, rb, 1'($urandom));
        end
        @(negedge clk);
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
